// File: rtl/btb_set_assoc.sv
// Set-associative BTB: combinational lookup, updates commit on the clk edge, upd_mispredict follows one cycle later.
// No backpressure; ready stays low while the post-reset sweep clears the valid bits. BTB_STATS_EN adds stat counters.
module btb_set_assoc #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int WAYS     = 2,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic            upd_mispredict,
    output logic            ready
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_mispredicts
`endif
);
    localparam int SETS = ENTRIES / WAYS;
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = XLEN - IDX - 2;
    localparam int SW   = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {S_SWEEP, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       cnt_q, cnt_d;
    logic                run;
    logic                mis_q, mis_d;

    logic [WAYS-1:0]     valid_q [SETS];
    logic [WW-1:0]       rr_q    [SETS];
    logic [TAG-1:0]      tag_q   [SETS][WAYS];
    logic [XLEN-1:0]     tgt_q   [SETS][WAYS];
    logic [CTR_BITS-1:0] ctr_q   [SETS][WAYS];

    function automatic logic [SW-1:0] idx_of(input logic [XLEN-1:0] pc);
        logic [XLEN-1:0] s;
        s = pc >> 2;
        return (SETS > 1) ? s[SW-1:0] : '0;
    endfunction

    function automatic logic [TAG-1:0] tag_of(input logic [XLEN-1:0] pc);
        logic [XLEN-1:0] s;
        s = pc >> (IDX + 2);
        return s[TAG-1:0];
    endfunction

    // FSM: state register, next-state logic, outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_SWEEP) begin
            cnt_d = cnt_q + SW'(1);
            if (cnt_q == SW'(SETS - 1)) state_d = S_RUN;
        end
    end

    always_comb begin
        run   = (state_q == S_RUN);
        ready = run;
    end

    logic [SW-1:0] l_idx, u_idx;
    logic [TAG-1:0] l_tag, u_tag;
    logic          l_hit, u_hit, u_free;
    logic [WW-1:0] l_way, u_way, u_fway, victim;

    // Descending scan so the lowest matching / free way wins
    always_comb begin
        l_idx  = idx_of(lookup_pc);
        l_tag  = tag_of(lookup_pc);
        u_idx  = idx_of(upd_pc);
        u_tag  = tag_of(upd_pc);
        l_hit  = 1'b0;
        l_way  = '0;
        u_hit  = 1'b0;
        u_way  = '0;
        u_free = 1'b0;
        u_fway = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
                l_hit = 1'b1;
                l_way = WW'(w);
            end
            if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = WW'(w);
            end
            if (!valid_q[u_idx][w]) begin
                u_free = 1'b1;
                u_fway = WW'(w);
            end
        end
        victim = u_free ? u_fway : rr_q[u_idx];
    end

    assign pred_hit    = run & l_hit;
    assign pred_taken  = pred_hit & ctr_q[l_idx][l_way][CTR_BITS-1];
    assign pred_target = pred_hit ? tgt_q[l_idx][l_way] : '0;

    logic u_ptaken, do_upd, do_alloc;
    assign u_ptaken = u_hit & ctr_q[u_idx][u_way][CTR_BITS-1];
    assign do_upd   = run & upd_valid & ~rst;
    assign do_alloc = do_upd & ~u_hit & upd_taken;
    assign mis_d    = run & upd_valid &
                      ((u_ptaken != upd_taken) |
                       (u_ptaken & upd_taken & (tgt_q[u_idx][u_way] != upd_target)));

    always_ff @(posedge clk) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= mis_d;
    end
    assign upd_mispredict = mis_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_SWEEP) begin
                valid_q[cnt_q] <= '0;
                rr_q[cnt_q]    <= '0;
            end else if (do_alloc) begin
                valid_q[u_idx][victim] <= 1'b1;
                if (!u_free) rr_q[u_idx] <= (WAYS > 1) ? rr_q[u_idx] + WW'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_upd) begin
            if (u_hit) begin
                if (upd_taken) begin
                    tgt_q[u_idx][u_way] <= upd_target;
                    if (ctr_q[u_idx][u_way] != '1)
                        ctr_q[u_idx][u_way] <= ctr_q[u_idx][u_way] + CTR_BITS'(1);
                end else if (ctr_q[u_idx][u_way] != '0) begin
                    ctr_q[u_idx][u_way] <= ctr_q[u_idx][u_way] - CTR_BITS'(1);
                end
            end else if (upd_taken) begin
                tag_q[u_idx][victim] <= u_tag;
                tgt_q[u_idx][victim] <= upd_target;
                ctr_q[u_idx][victim] <= CTR_BITS'(1) << (CTR_BITS - 1);
            end
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            stat_lookups     <= '0;
            stat_hits        <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_lookups     <= stat_lookups + 32'd1;
            stat_hits        <= stat_hits + {31'd0, pred_hit};
            stat_mispredicts <= stat_mispredicts + {31'd0, mis_q};
        end
    end
`endif
endmodule

// File: tb/tb_btb_set_assoc.sv
// Bench for btb_set_assoc: directed scenarios with literal expectations, then randomized traffic vs. a table model.
module tb_btb_set_assoc;
    localparam int SETS = 8;
    localparam int WAYS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lookup_pc = '0;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict, ready;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

    int checks = 0;
    int failures = 0;

    btb_set_assoc dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .ready(ready)
`ifdef BTB_STATS_EN
        , .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a table of entries per set, plus a countdown of not-ready cycles.
    bit          m_init = 0;
    int          m_sweep = 0;
    bit          m_mis = 0;
    bit          m_valid [SETS][WAYS];
    logic [31:0] m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int          m_ctr   [SETS][WAYS];
    int          m_rr    [SETS];

    function automatic void mlook(input logic [31:0] pc, output bit hit, output int way);
        int s;
        s = int'((pc >> 2) % SETS);
        hit = 0;
        way = 0;
        for (int w = 0; w < WAYS; w++)
            if (!hit && m_valid[s][w] && m_tag[s][w] == (pc >> 5)) begin
                hit = 1;
                way = w;
            end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1;
            m_sweep = SETS;
            m_mis = 0;
            for (int s = 0; s < SETS; s++) begin
                m_rr[s] = 0;
                for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
            end
        end else if (m_init) begin
            if (m_sweep > 0) begin
                m_sweep--;
                m_mis = 0;
            end else begin
                bit h, pt, nm;
                int w, s, v;
                nm = 0;
                if (upd_valid) begin
                    s = int'((upd_pc >> 2) % SETS);
                    mlook(upd_pc, h, w);
                    pt = h && m_ctr[s][w] >= 2;
                    nm = (pt != upd_taken) || (pt && upd_taken && m_tgt[s][w] != upd_target);
                    if (h) begin
                        if (upd_taken) begin
                            m_tgt[s][w] = upd_target;
                            if (m_ctr[s][w] < 3) m_ctr[s][w]++;
                        end else if (m_ctr[s][w] > 0) m_ctr[s][w]--;
                    end else if (upd_taken) begin
                        v = -1;
                        for (int k = WAYS - 1; k >= 0; k--) if (!m_valid[s][k]) v = k;
                        if (v < 0) begin
                            v = m_rr[s];
                            m_rr[s] = (m_rr[s] + 1) % WAYS;
                        end
                        m_valid[s][v] = 1;
                        m_tag[s][v] = upd_pc >> 5;
                        m_tgt[s][v] = upd_target;
                        m_ctr[s][v] = 2;
                    end
                end
                m_mis = nm;
            end
        end
    end

    // Compare process: every cycle once the model knows the DUT has been reset
    always @(negedge clk) begin
        #1;
        if (m_init) begin
            bit h;
            int w, s;
            chk("ready", {31'd0, ready}, {31'd0, m_sweep == 0});
            chk("upd_mispredict", {31'd0, upd_mispredict}, {31'd0, m_mis});
            if (m_sweep > 0) begin
                h = 0;
                w = 0;
            end else mlook(lookup_pc, h, w);
            s = int'((lookup_pc >> 2) % SETS);
            chk("pred_hit", {31'd0, pred_hit}, {31'd0, h});
            chk("pred_taken", {31'd0, pred_taken}, {31'd0, h && m_ctr[s][w] >= 2});
            chk("pred_target", pred_target, h ? m_tgt[s][w] : 32'd0);
        end
    end

    task automatic drive(input logic r, input logic [31:0] lpc, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utg);
        @(negedge clk);
        rst = r;
        lookup_pc = lpc;
        upd_valid = uv;
        upd_pc = upc;
        upd_taken = ut;
        upd_target = utg;
        #2;
    endtask

    task automatic look(input logic [31:0] lpc);
        drive(0, lpc, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rndpc();
        return (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        drive(1, 32'h100, 0, 0, 0, 0);
        for (int i = 0; i < SETS; i++) begin
            look(32'h100);
            chk("sweep_ready_low", {31'd0, ready}, 32'd0);
            chk("sweep_no_hit", {31'd0, pred_hit}, 32'd0);
        end
        drive(0, 32'h100, 1, 32'h100, 1, 32'h200);
        chk("ready_after_sweep", {31'd0, ready}, 32'd1);
        chk("first_miss", {31'd0, pred_hit}, 32'd0);
        look(32'h100);
        chk("alloc_hit", {31'd0, pred_hit}, 32'd1);
        chk("alloc_taken", {31'd0, pred_taken}, 32'd1);
        chk("alloc_target", pred_target, 32'h200);
        chk("alloc_mispredict", {31'd0, upd_mispredict}, 32'd1);
        drive(0, 32'h100, 1, 32'h100, 0, 0);
        chk("ctr2_taken", {31'd0, pred_taken}, 32'd1);
        drive(0, 32'h100, 1, 32'h100, 0, 0);
        chk("ctr1_taken", {31'd0, pred_taken}, 32'd0);
        chk("nt_mispredict", {31'd0, upd_mispredict}, 32'd1);
        drive(0, 32'h100, 1, 32'h100, 1, 32'h200);
        chk("ctr0_hit", {31'd0, pred_hit}, 32'd1);
        chk("ctr0_taken", {31'd0, pred_taken}, 32'd0);
        chk("ctr0_nomis", {31'd0, upd_mispredict}, 32'd0);
        look(32'h100);
        chk("ctr1_after_taken", {31'd0, pred_taken}, 32'd0);
        chk("taken_mispredict", {31'd0, upd_mispredict}, 32'd1);

        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < SETS; i++) look(0);
        drive(0, 0, 1, 32'h100, 1, 32'h1000);
        drive(0, 0, 1, 32'h120, 1, 32'h1200);
        drive(0, 0, 1, 32'h140, 1, 32'h1400);
        look(32'h100);
        chk("evicted_miss", {31'd0, pred_hit}, 32'd0);
        look(32'h120);
        chk("way1_hit", {31'd0, pred_hit}, 32'd1);
        chk("way1_target", pred_target, 32'h1200);
        look(32'h140);
        chk("new_hit", {31'd0, pred_hit}, 32'd1);
        chk("new_target", pred_target, 32'h1400);
        drive(0, 32'h300, 1, 32'h300, 0, 32'h3000);
        look(32'h300);
        chk("nt_noalloc", {31'd0, pred_hit}, 32'd0);
        chk("nt_miss_nomis", {31'd0, upd_mispredict}, 32'd0);
        drive(0, 32'h180, 1, 32'h180, 1, 32'h1800);
        chk("same_cycle_old", {31'd0, pred_hit}, 32'd0);
        look(32'h180);
        chk("same_cycle_new", {31'd0, pred_hit}, 32'd1);
        chk("same_cycle_tgt", pred_target, 32'h1800);

        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) look(0);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < SETS; i++) begin
            look(32'h180);
            chk("resweep_ready_low", {31'd0, ready}, 32'd0);
        end
        drive(0, 32'h500, 1, 32'h100, 1, 32'h2000);
        chk("resweep_ready", {31'd0, ready}, 32'd1);
        chk("resweep_cleared", {31'd0, pred_hit}, 32'd0);
        for (int i = 0; i < 4; i++) look(32'h100);
        for (int i = 0; i < 5; i++) look(32'h500);
        look(0);
`ifdef BTB_STATS_EN
        chk("stat_lookups", stat_lookups, 32'd10);
        chk("stat_hits", stat_hits, 32'd4);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] lp, up;
            lp = rndpc();
            up = ($urandom_range(0, 3) == 0) ? lp : rndpc();
            drive($urandom_range(0, 299) == 0, lp, $urandom_range(0, 3) != 0, up,
                  1'($urandom_range(0, 1)), 32'h10000 | (32'($urandom_range(0, 3)) << 8));
        end

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
